// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Response-wait counter: cleared while a request is pending, counts WAIT cycles,
// flags when the configured maximum has been reached.
module fetch_timeout_ctr #(
  parameter int unsigned           TIMEOUT_W   = 8,
  parameter logic [TIMEOUT_W-1:0]  TIMEOUT_MAX = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMEOUT_W-1:0] count;

  // Wait-cycle count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {TIMEOUT_W{1'b0}};
    end else if (clear) begin
      count <= {TIMEOUT_W{1'b0}};
    end else if (enable) begin
      count <= count + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign expired = (count == TIMEOUT_MAX);

endmodule

// File: rtl/instr_fetch_unit.sv
// PC register and single-outstanding instruction fetch sequencer with a
// valid/ready hand-off to decode and sticky misalignment / timeout flags.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0]          RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned          TIMEOUT_W   = 8,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_address,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        misaligned,
  output logic        bus_error
);

  fetch_state_t state, state_nx;
  logic [31:0]  pc, pc_nx;
  logic [31:0]  instr_nx;
  logic         misaligned_nx, bus_error_nx;
  logic         ctr_clear, ctr_enable, ctr_expired;

  fetch_timeout_ctr #(
    .TIMEOUT_W   (TIMEOUT_W),
    .TIMEOUT_MAX (TIMEOUT_MAX)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (ctr_clear),
    .enable  (ctr_enable),
    .expired (ctr_expired)
  );

  // Next-state, next-PC and flag logic
  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    instr_nx      = instr;
    misaligned_nx = misaligned;
    bus_error_nx  = bus_error;
    ctr_clear     = 1'b0;
    ctr_enable    = 1'b0;
    case (state)
      FETCH: begin
        // rvalid without gnt here is a stale response and is ignored
        ctr_clear = 1'b1;
        if (imem_gnt) begin
          if (imem_rvalid) begin
            instr_nx = imem_rdata;
            state_nx = VALID;
          end else begin
            state_nx = WAIT;
          end
        end else begin
          state_nx = FETCH;
        end
      end
      WAIT: begin
        ctr_enable = 1'b1;
        if (imem_rvalid) begin
          instr_nx = imem_rdata;
          state_nx = VALID;
        end else if (ctr_expired) begin
          bus_error_nx = 1'b1;
          state_nx     = HALT;
        end else begin
          state_nx = WAIT;
        end
      end
      VALID: begin
        if (instr_ready) begin
          pc_nx = next_pc;
          if (next_pc[1:0] == 2'b00) begin
            state_nx = FETCH;
          end else begin
            misaligned_nx = 1'b1;
            state_nx      = HALT;
          end
        end else begin
          state_nx = VALID;
        end
      end
      HALT: begin
        state_nx = HALT;
      end
      default: begin
        state_nx = HALT;
      end
    endcase
  end

  // State, PC, instruction and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= INSTR_NOP;
      misaligned  <= 1'b0;
      bus_error   <= 1'b0;
      imem_req    <= 1'b1;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      instr       <= instr_nx;
      misaligned  <= misaligned_nx;
      bus_error   <= bus_error_nx;
      imem_req    <= (state_nx == FETCH);
      instr_valid <= (state_nx == VALID);
    end
  end

  assign imem_addr  = pc;
  assign pc_address = pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] next_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc_address;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        misaligned;
  logic        bus_error;

  int vectors = 0;
  int miscompares = 0;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .next_pc     (next_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc_address  (pc_address),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .misaligned  (misaligned),
    .bus_error   (bus_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0; next_pc = 32'h0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // zero-latency fetch then hand-off with the given next_pc
  task automatic fetch_and_retire(input logic [31:0] data, input logic [31:0] npc);
    imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = data;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b1; next_pc = npc;
    step();
    instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({imem_req, instr_valid, misaligned, bus_error} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_flags: req/valid/mis/berr=%b expected 1000",
               {imem_req, instr_valid, misaligned, bus_error});
    end
    vectors++;
    if (imem_addr !== 32'h0 || pc_address !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_pc: addr=%h pc=%h expected 0", imem_addr, pc_address);
    end
    vectors++;
    if (instr !== 32'h0000_0013) begin
      miscompares++;
      $display("FAIL reset_instr: instr=%h expected 00000013", instr);
    end
  endtask

  task automatic test_zero_latency();
    do_reset();
    imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    vectors++;
    if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL zl_valid: valid=%b instr=%h req=%b expected 1 00500093 0",
               instr_valid, instr, imem_req);
    end
    instr_ready = 1'b1; next_pc = 32'h4;
    step();
    instr_ready = 1'b0;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL zl_next: req=%b addr=%h valid=%b expected 1 00000004 0",
               imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_variable_latency();
    // continues from pc=4 in FETCH
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    vectors++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL vl_wait: req=%b valid=%b expected 0 0", imem_req, instr_valid);
    end
    step();
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0063;
    step();
    imem_rvalid = 1'b0; imem_rdata = 32'hFFFF_FFFF;
    next_pc = 32'h40; instr_ready = 1'b0;
    vectors++;
    if (instr_valid !== 1'b1 || instr !== 32'h0000_0063) begin
      miscompares++;
      $display("FAIL vl_valid: valid=%b instr=%h expected 1 00000063", instr_valid, instr);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (instr_valid !== 1'b1 || instr !== 32'h0000_0063 || pc_address !== 32'h4) begin
        miscompares++;
        $display("FAIL vl_hold%0d: valid=%b instr=%h pc=%h expected 1 00000063 00000004",
                 i, instr_valid, instr, pc_address);
      end
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      miscompares++;
      $display("FAIL vl_next: req=%b addr=%h expected 1 00000040", imem_req, imem_addr);
    end
  endtask

  task automatic test_misaligned();
    logic saw_req;
    fetch_and_retire(32'h0000_0013, 32'h0000_0042);
    vectors++;
    if (misaligned !== 1'b1 || pc_address !== 32'h42 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mis_flag: mis=%b pc=%h req=%b valid=%b expected 1 00000042 0 0",
               misaligned, pc_address, imem_req, instr_valid);
    end
    saw_req = 1'b0;
    imem_gnt = 1'b1; imem_rvalid = 1'b1; instr_ready = 1'b1; next_pc = 32'h8;
    for (int i = 0; i < 5; i++) begin
      step();
      saw_req = saw_req | imem_req | instr_valid;
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0;
    vectors++;
    if (saw_req !== 1'b0 || pc_address !== 32'h42 || misaligned !== 1'b1) begin
      miscompares++;
      $display("FAIL mis_halt: activity=%b pc=%h mis=%b expected 0 00000042 1",
               saw_req, pc_address, misaligned);
    end
  endtask

  task automatic test_timeout();
    logic early;
    do_reset();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 255; i++) begin
      step();
      early = early | bus_error | imem_req;
    end
    vectors++;
    if (early !== 1'b0) begin
      miscompares++;
      $display("FAIL to_early: error/req seen before 256 wait cycles=%b expected 0", early);
    end
    step();
    vectors++;
    if (bus_error !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL to_error: berr=%b req=%b valid=%b expected 1 0 0",
               bus_error, imem_req, instr_valid);
    end
    imem_gnt = 1'b1; imem_rvalid = 1'b1;
    step();
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    vectors++;
    if (bus_error !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL to_halt: berr=%b req=%b valid=%b expected 1 0 0",
               bus_error, imem_req, instr_valid);
    end
    // rvalid on the very last permitted wait cycle
    do_reset();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    for (int i = 0; i < 255; i++) begin
      step();
    end
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_ABCD;
    step();
    imem_rvalid = 1'b0;
    vectors++;
    if (bus_error !== 1'b0 || instr_valid !== 1'b1 || instr !== 32'h1234_ABCD) begin
      miscompares++;
      $display("FAIL to_last: berr=%b valid=%b instr=%h expected 0 1 1234abcd",
               bus_error, instr_valid, instr);
    end
  endtask

  task automatic test_reset_in_wait();
    logic seen_valid;
    do_reset();
    fetch_and_retire(32'h0000_0013, 32'h0000_0100);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    seen_valid = instr_valid;
    step();
    seen_valid = seen_valid | instr_valid;
    vectors++;
    if (seen_valid !== 1'b0 || imem_addr !== 32'h0 || imem_req !== 1'b1 || instr !== 32'h0000_0013) begin
      miscompares++;
      $display("FAIL rst_wait: valid=%b addr=%h req=%b instr=%h expected 0 00000000 1 00000013",
               seen_valid, imem_addr, imem_req, instr);
    end
  endtask

  task automatic test_wrap();
    logic unstable;
    do_reset();
    fetch_and_retire(32'h0000_0013, 32'hFFFF_FFFC);
    unstable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      unstable = unstable | ~imem_req | (imem_addr != 32'hFFFF_FFFC);
    end
    vectors++;
    if (unstable !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_stall: req/addr changed while gnt=0 (%b) expected 0", unstable);
    end
    fetch_and_retire(32'h0000_0013, 32'h0000_0000);
    vectors++;
    if (imem_addr !== 32'h0 || imem_req !== 1'b1 || misaligned !== 1'b0 || bus_error !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_next: addr=%h req=%b mis=%b berr=%b expected 00000000 1 0 0",
               imem_addr, imem_req, misaligned, bus_error);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_zero_latency();
    test_variable_latency();
    test_misaligned();
    test_timeout();
    test_reset_in_wait();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
